// File: rtl/hog_feature_readout_pkg.sv
// Shared widths, defaults and types for the HOG feature readout block.
package hog_feature_readout_pkg;

  localparam int QN             = 8;
  localparam int WORD_W         = 4 * QN;
  localparam int ADDR_W_DEF     = 13;
  localparam int FEAT_DEPTH_DEF = 1156;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } state_t;

  // One FIFO entry: packed bank bytes plus the end-of-frame tag.
  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } fifo_word_t;

endpackage

// File: rtl/hog_feature_readout_if.sv
// Valid/ready word stream from the feature readout toward the DMA side.
interface hog_feature_readout_if;
  import hog_feature_readout_pkg::*;

  logic [WORD_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/hog_feature_readout_fifo2.sv
// Two-entry register FIFO that catches BRAM read data ahead of the output stream.
module hog_feat_fifo2
  import hog_feature_readout_pkg::*;
(
  input  logic       aclk,
  input  logic       arest,
  input  logic       push,
  input  fifo_word_t din,
  input  logic       pop,
  output fifo_word_t dout,
  output logic [1:0] count,
  output logic       empty,
  output logic       full
);

  fifo_word_t mem_reg [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       wr_en;
  logic       rd_en;

  assign empty = (count_reg == 2'd0);
  assign full  = (count_reg == 2'd2);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign count = count_reg;
  assign dout  = mem_reg[rd_ptr_reg];

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge aclk or posedge arest) begin
      if (arest) begin
        mem_reg[gi] <= '0;
      end else if (wr_en && (wr_ptr_reg == 1'(gi))) begin
        mem_reg[gi] <= din;
      end
    end
  end

  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (wr_en) wr_ptr_reg <= ~wr_ptr_reg;
      if (rd_en) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, wr_en} - {1'b0, rd_en};
    end
  end

endmodule

// File: rtl/hog_feature_readout.sv
// Sweeps the four HOG result banks in lock-step after feature-done and streams
// one packed 32-bit word per address, absorbing BRAM latency and backpressure.
module hog_feature_readout
  import hog_feature_readout_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FEAT_DEPTH = FEAT_DEPTH_DEF
) (
  input  logic              aclk,
  input  logic              arest,
  input  logic              write_feature_done,
  output logic              res_enb_0,
  output logic              res_enb_1,
  output logic              res_enb_2,
  output logic              res_enb_3,
  output logic [ADDR_W-1:0] res_addrb_0,
  output logic [ADDR_W-1:0] res_addrb_1,
  output logic [ADDR_W-1:0] res_addrb_2,
  output logic [ADDR_W-1:0] res_addrb_3,
  input  logic [QN-1:0]     res_doutb_0,
  input  logic [QN-1:0]     res_doutb_1,
  input  logic [QN-1:0]     res_doutb_2,
  input  logic [QN-1:0]     res_doutb_3,
  hog_feature_readout_if.master m,
  output logic              busy,
  output logic              readout_done
);

  if (FEAT_DEPTH < 1 || FEAT_DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("hog_feature_readout: FEAT_DEPTH out of range 1..2**ADDR_W");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FEAT_DEPTH - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
  logic              inflight_reg;
  logic              inflight_last_reg;
  logic              done_reg, done_next;
  logic              issue;
  logic              is_last;
  logic              pop;
  logic              credit_ok;
  logic [1:0]        occ;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  fifo_word_t        push_word;
  fifo_word_t        head;

  assign is_last = (rd_addr_reg == LAST_ADDR);
  assign pop     = !fifo_empty && m.tready;
  assign occ     = fifo_count + {1'b0, inflight_reg};
  // The same-cycle pop frees a slot, which is what allows one word per cycle.
  assign credit_ok = pop || (!fifo_full && (occ < 2'd2));

  always_comb begin
    state_next   = state_reg;
    rd_addr_next = rd_addr_reg;
    done_next    = 1'b0;
    issue        = 1'b0;
    case (state_reg)
      ST_IDLE:  issue = write_feature_done;
      ST_READ:  issue = credit_ok;
      ST_DRAIN: begin
        if (pop && head.last) begin
          state_next   = ST_IDLE;
          rd_addr_next = '0;
          done_next    = 1'b1;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
    if (issue) begin
      if (is_last) begin
        state_next = ST_DRAIN;
      end else begin
        state_next   = ST_READ;
        rd_addr_next = rd_addr_reg + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      state_reg         <= ST_IDLE;
      rd_addr_reg       <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      done_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      rd_addr_reg       <= rd_addr_next;
      inflight_reg      <= issue;
      inflight_last_reg <= issue && is_last;
      done_reg          <= done_next;
    end
  end

  assign res_enb_0   = issue;
  assign res_enb_1   = issue;
  assign res_enb_2   = issue;
  assign res_enb_3   = issue;
  assign res_addrb_0 = issue ? rd_addr_reg : '0;
  assign res_addrb_1 = issue ? rd_addr_reg : '0;
  assign res_addrb_2 = issue ? rd_addr_reg : '0;
  assign res_addrb_3 = issue ? rd_addr_reg : '0;

  assign push_word = '{last: inflight_last_reg,
                       data: {res_doutb_3, res_doutb_2, res_doutb_1, res_doutb_0}};

  hog_feat_fifo2 u_fifo (
    .aclk  (aclk),
    .arest (arest),
    .push  (inflight_reg),
    .din   (push_word),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign m.tvalid     = !fifo_empty;
  assign m.tdata      = fifo_empty ? '0 : head.data;
  assign m.tlast      = !fifo_empty && head.last;
  assign busy         = (state_reg != ST_IDLE);
  assign readout_done = done_reg;

endmodule
